// File: rtl/bm_block_quantizer.sv
// Block-minifloat encoder: buffers N floats, derives a shared bias from the
// block's largest exponent, then streams out (1+e+m)-bit BM elements.
module bm_block_quantizer #(
  parameter int e  = 3,
  parameter int m  = 4,
  parameter int E  = 8,
  parameter int M  = 23,
  parameter int sb = 3,
  parameter int N  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+M:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [e+m:0]     out_data,
  output logic [sb-1:0]    out_bias,
  output logic             out_last,
  output logic             FLAG_exp_overflow
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = E + 2;
  localparam int FB = 2**(E-1) - 1;
  localparam int B  = 2**(e-1) - 1;
  localparam int XMAX = 2**e - 1;

  localparam logic signed [XW-1:0] FB_X   = XW'(FB);
  localparam logic signed [XW-1:0] B_X    = XW'(B);
  localparam logic signed [XW-1:0] TOP_X  = XW'(XMAX - B);
  localparam logic signed [XW-1:0] XMAX_X = XW'(XMAX);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] SMAX_X = XW'(2**(sb-1) - 1);
  localparam logic signed [XW-1:0] SMIN_X = -XW'(2**(sb-1));

  typedef enum logic [1:0] {FILL, BIAS, DRAIN} state_t;

  state_t state, state_next;

  logic [E+M:0]          buf_mem [N];
  logic [IW-1:0]         wr_idx, rd_idx;
  logic [E-1:0]          emax;
  logic signed [sb-1:0]  s_bias;

  logic                  in_fire, out_fire, wr_last, rd_last;
  logic [E-1:0]          in_ef;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wr_last   = (wr_idx == IW'(N - 1));
  assign rd_last   = (rd_idx == IW'(N - 1));
  assign in_ef     = in_data[E+M-1:M];

  // Shared bias: puts the block's largest exponent in the top BM binade.
  logic signed [XW-1:0] s_raw;
  logic signed [sb-1:0] s_calc;
  always_comb begin
    s_raw  = $signed({2'b00, emax}) - FB_X - TOP_X;
    s_calc = '0;
    if (emax != '0) begin
      if (s_raw > SMAX_X)      s_calc = sb'(SMAX_X);
      else if (s_raw < SMIN_X) s_calc = sb'(SMIN_X);
      else                     s_calc = sb'(s_raw);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (in_fire && wr_last)   state_next = BIAS;
      BIAS:                              state_next = DRAIN;
      DRAIN:   if (out_fire && rd_last)  state_next = FILL;
      default:                           state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      wr_idx <= '0;
      rd_idx <= '0;
      emax   <= '0;
      s_bias <= '0;
    end else begin
      state <= state_next;
      if (in_fire) begin
        wr_idx <= wr_idx + IW'(1);
        if (in_ef != '0 && in_ef > emax) emax <= in_ef;
      end
      if (state == BIAS) s_bias <= s_calc;
      if (out_fire) begin
        if (rd_last) begin
          rd_idx <= '0;
          wr_idx <= '0;
          emax   <= '0;
        end else begin
          rd_idx <= rd_idx + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[wr_idx] <= in_data;
  end

  // Element conversion from the buffered word and the registered bias.
  logic [E+M:0]          cur;
  logic                  cur_s;
  logic [E-1:0]          cur_ef;
  logic [m:0]            f_sum;
  logic [m-1:0]          f_rnd;
  logic signed [XW-1:0]  x_pre, x_rnd, s_ext;
  logic                  rd_unused;

  always_comb begin
    cur       = buf_mem[rd_idx];
    cur_s     = cur[E+M];
    cur_ef    = cur[E+M-1:M];
    rd_unused = ^cur[M-m-2:0];
    s_ext     = $signed({{(XW-sb){s_bias[sb-1]}}, s_bias});
    x_pre     = $signed({2'b00, cur_ef}) - FB_X - s_ext + B_X;
    f_sum     = {1'b0, cur[M-1 -: m]} + (m+1)'(cur[M-m-1]);
    x_rnd     = f_sum[m] ? x_pre + ONE_X : x_pre;
    f_rnd     = f_sum[m] ? '0 : f_sum[m-1:0];

    out_data          = '0;
    FLAG_exp_overflow = 1'b0;
    if (state == DRAIN && cur_ef != '0) begin
      if (&cur_ef || x_rnd > XMAX_X) begin
        out_data          = {cur_s, {(e+m){1'b1}}};
        FLAG_exp_overflow = 1'b1;
      end else if (x_rnd >= ONE_X) begin
        out_data = {cur_s, x_rnd[e-1:0], f_rnd};
      end
    end
  end

  assign out_bias = s_bias;
  assign out_last = (state == DRAIN) && rd_last;

endmodule

// File: tb/tb_bm_block_quantizer.sv
// Scoreboard bench for bm_block_quantizer at N=4: expected elements are queued
// as each block is driven and compared as the DUT hands them out.
module tb_bm_block_quantizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_bias;
  logic        out_last;
  logic        flag;

  int checks   = 0;
  int failures = 0;

  // {flag, last, bias[2:0], data[7:0]}
  logic [12:0] sb_q[$];

  always #5 clk = ~clk;

  bm_block_quantizer #(.e(3), .m(4), .E(8), .M(23), .sb(3), .N(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_bias          (out_bias),
    .out_last          (out_last),
    .FLAG_exp_overflow (flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] b, input logic l, input logic f);
    sb_q.push_back({f, l, b, d});
  endtask

  task automatic push_block(input logic [7:0] d0, d1, d2, d3, input logic [2:0] b,
                            input logic f0, f1, f2, f3);
    push(d0, b, 1'b0, f0);
    push(d1, b, 1'b0, f1);
    push(d2, b, 1'b0, f2);
    push(d3, b, 1'b1, f3);
  endtask

  // Entered and left on a negedge; each word transfers on the following posedge.
  task automatic feed(input logic [31:0] w0, w1, w2, w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      int cnt = 0;
      in_data  = w[i];
      in_valid = 1'b1;
      while (!in_ready && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    // Now in the BIAS cycle.
    check("bias_in_ready", 32'(in_ready), 32'd0);
    check("bias_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic drain(input int n_items, input int stall_after);
    int got = 0;
    int cyc = 0;
    int stall = 0;
    bit first = 1'b1;
    logic [12:0] ex;
    out_ready = 1'b1;
    while (got < n_items && cyc < 200) begin
      if (out_valid) begin
        if (first) begin
          check("first_valid_latency", 32'(cyc), 32'd1);
          first = 1'b0;
        end
        check("drain_in_ready", 32'(in_ready), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          ex = sb_q[0];
          check("out_data", 32'(out_data), 32'(ex[7:0]));
          check("out_bias", 32'(out_bias), 32'(ex[10:8]));
          check("out_last", 32'(out_last), 32'(ex[11]));
          check("flag_exp_overflow", 32'(flag), 32'(ex[12]));
          if (out_ready) begin
            $display("xfer data=0x%02h bias=%0d last=%0b flag=%0b",
                     out_data, $signed(out_bias), out_last, flag);
            void'(sb_q.pop_front());
            got++;
            if (got == stall_after) stall = 3;
          end
        end
      end
      @(negedge clk);
      cyc++;
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = 1'b1;
      end
    end
    if (got < n_items) check("drain_timeout", 32'(got), 32'(n_items));
  endtask

  task automatic after_block();
    check("post_last_in_ready", 32'(in_ready), 32'd1);
    check("post_last_out_valid", 32'(out_valid), 32'd0);
    check("queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_bias", 32'(out_bias), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Nominal block, S = -3.
    push_block(8'h60, 8'h70, 8'hD0, 8'h00, 3'b101, 0, 0, 0, 0);
    feed(32'h3F800000, 32'h40000000, 32'hBF000000, 32'h00000000);
    drain(4, -1);
    after_block();

    // Large exponents: S clamps to +3 and every element saturates.
    push_block(8'h7F, 8'h7F, 8'h7F, 8'h7F, 3'b011, 1, 1, 1, 1);
    feed(32'h44800000, 32'h44800000, 32'h44800000, 32'h44800000);
    drain(4, -1);
    after_block();

    // S = -1 with an underflowing element flushed to zero.
    push_block(8'h70, 8'h10, 8'h00, 8'h00, 3'b111, 0, 0, 0, 0);
    feed(32'h41000000, 32'h3E000000, 32'h3D800000, 32'h00000000);
    drain(4, -1);
    after_block();

    // Rounding carry overflows the top binade.
    push_block(8'h7F, 8'h00, 8'h00, 8'h00, 3'b100, 1, 0, 0, 0);
    feed(32'h3FFC0000, 32'h00000000, 32'h00000000, 32'h00000000);
    drain(4, -1);
    after_block();

    // All-zero block, sink stalls 3 cycles after the 2nd element.
    push_block(8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0);
    feed(32'h0, 32'h0, 32'h0, 32'h0);
    drain(4, 2);
    after_block();

    // Reset in the middle of a drain, then the nominal block again.
    push_block(8'h60, 8'h70, 8'hD0, 8'h00, 3'b101, 0, 0, 0, 0);
    feed(32'h3F800000, 32'h40000000, 32'hBF000000, 32'h00000000);
    drain(2, -1);
    #1 reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_bias", 32'(out_bias), 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_block(8'h60, 8'h70, 8'hD0, 8'h00, 3'b101, 0, 0, 0, 0);
    feed(32'h3F800000, 32'h40000000, 32'hBF000000, 32'h00000000);
    drain(4, -1);
    after_block();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
